irq_dispatch: RTL and testbench
===============================

# irq_dispatch

Interrupt dispatch sequencer between the interrupt controller and the CPU core. It watches the controller's one-hot priority request and the NMI line, and applies the CPU's current interrupt mask. It runs the take/acknowledge handshake at instruction boundaries, then latches the vector byte that the controller drives during acknowledge. The CPU receives one registered vector-address/level pulse per accepted interrupt.

## Interface
- ACK_CYCLES, 2: cycles irq_iack is held before the vector is latched (min 1)
- GUARD_CYCLES, 1: cycles after vector delivery before new requests are evaluated (min 1)
- NMI_VECTOR, 8'h02: vector byte delivered for NMI
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- cpu_irq  in  4  from interrupt controller; bit n = request at priority level n (1..3); bit 0 ignored
- nmi  in  1  NMI level; rising edge sets NMI pending
- irq_vector  in  8  vector byte from controller, valid while irq_iack high
- cpu_imask  in  2  CPU interrupt mask level; maskable level L accepted only if L > cpu_imask
- cpu_boundary  in  1  CPU is at an instruction boundary this cycle
- cpu_irq_take  in  1  CPU accepts the pending request (only honoured with cpu_boundary)
- cpu_irq_req  out  1  interrupt request to CPU
- irq_iack  out  1  acknowledge to interrupt controller (drives its cpu_iack)
- vector_valid  out  1  one-cycle pulse: vector_addr/vector_level valid
- vector_addr  out  8  vector byte; held until next delivery
- vector_level  out  2  mask level CPU loads on entry (3 for NMI)
- spurious  out  1  one-cycle pulse: maskable request vanished during acknowledge
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, REQ, ACK, VEC, GUARD.
- Candidate, re-evaluated combinationally each cycle:
  - NMI if nmi_pend, level 3, regardless of cpu_imask.
  - Otherwise highest set bit L of cpu_irq[3:1] with L > cpu_imask.
- IDLE: candidate present -> REQ.
- REQ: cpu_irq_req=1.
  - cpu_irq_take & cpu_boundary -> latch source (NMI/maskable) and level; clear nmi_pend if NMI; load counter with ACK_CYCLES; -> ACK.
  - No candidate -> IDLE (request withdrawn).
  - cpu_irq_take without cpu_boundary is ignored.
- ACK: irq_iack=1 for a maskable source and 0 for NMI; counter decrements. On the last cycle:
  - NMI: latch NMI_VECTOR -> VEC.
  - Maskable, cpu_irq[latched level] still set: latch irq_vector -> VEC.
  - Otherwise: spurious -> GUARD without vector_valid.
- VEC: vector_valid=1, vector_level = latched level; load counter with GUARD_CYCLES; -> GUARD.
- GUARD: counter decrements; at 0 -> IDLE.
- NMI edge detector: nmi_q register.
  - Rising edge (nmi & ~nmi_q) sets nmi_pend in any state, including during a maskable ACK.
  - nmi_pend is cleared only on take of the NMI.
  - A second edge while pending is merged.
- Widths: counter is wide enough for max(ACK_CYCLES, GUARD_CYCLES). Level comparison is unsigned 2-bit, so cpu_imask=3 blocks all maskable requests.

## Timing
- All outputs registered. Reset values:
  - cpu_irq_req, irq_iack, vector_valid, spurious, busy = 0.
  - vector_addr = 8'h00, vector_level = 0.
  - nmi_pend = 0, nmi_q = 1 (NMI held high through reset does not trigger).
  - State IDLE.
- Candidate appears in cycle C -> cpu_irq_req high from C+1.
- Take sampled in cycle T:
  - irq_iack high T+1..T+ACK_CYCLES.
  - Vector latched at end of T+ACK_CYCLES.
  - vector_valid in T+ACK_CYCLES+1.
  - GUARD T+ACK_CYCLES+2..T+ACK_CYCLES+1+GUARD_CYCLES.
  - IDLE next cycle.
- cpu_irq_req drops in T+1.
- Earliest next cpu_irq_req: two cycles after GUARD ends (IDLE, then REQ).
- Reset asserted mid-sequence: next cycle returns to reset values; irq_iack drops with no vector_valid.

## Test plan
- Maskable basic: cpu_imask=0, cpu_irq=4'b0100, irq_vector=8'h1C, take+boundary at T -> irq_iack T+1..T+2; vector_valid at T+3 with vector_addr=8'h1C, vector_level=2; busy low at T+5.
- Masking: cpu_irq=4'b0010 with cpu_imask=1 -> cpu_irq_req stays 0. Raise cpu_irq to 4'b1000 -> req next cycle; delivered vector_level=3.
- NMI priority: nmi rising edge while cpu_irq=4'b1000, cpu_imask=3 -> req; take -> irq_iack stays 0; vector_addr=8'h02, vector_level=3; nmi_pend cleared.
- Withdraw/spurious:
  - cpu_irq cleared in REQ before take -> req drops, no iack.
  - cpu_irq cleared during ACK -> spurious pulse at T+3, no vector_valid.
- Boundary gating and NMI during ACK: take without boundary is ignored. NMI edge during maskable ACK -> maskable vector delivered first; NMI req appears after GUARD, with NMI_VECTOR next.
- Reset mid-ACK: assert reset at T+1 -> all outputs 0 next cycle; nmi held high across reset release produces no request.

Source files
------------

// File: rtl/irq_dispatch.sv
// irq_dispatch
//
// Interrupt dispatch sequencer between the interrupt controller and the CPU.
// It picks the best request (pending NMI first, then the highest unmasked
// maskable level) and raises cpu_irq_req. When the CPU takes the request at
// an instruction boundary, it acknowledges the controller for ACK_CYCLES
// cycles (no acknowledge for NMI). It then latches the vector byte and gives
// the CPU a one-cycle vector_valid pulse. A short guard period follows before
// new requests are evaluated. If a maskable request disappears during the
// acknowledge, a one-cycle spurious pulse replaces the vector delivery.
//
// Parameters
//   ACK_CYCLES    cycles irq_iack is held before the vector is latched (>= 1)
//   GUARD_CYCLES  cycles after delivery before new requests count (>= 1)
//   NMI_VECTOR    vector byte delivered for NMI
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   cpu_irq       one-hot-ish priority request from controller, bits 3..1
//   nmi           NMI level, rising edge sets NMI pending
//   irq_vector    vector byte from controller, valid while irq_iack is high
//   cpu_imask     CPU mask level; maskable level L accepted only if L > mask
//   cpu_boundary  CPU is at an instruction boundary this cycle
//   cpu_irq_take  CPU accepts the pending request (needs cpu_boundary)
//   cpu_irq_req   interrupt request to CPU
//   irq_iack      acknowledge to interrupt controller
//   vector_valid  one-cycle pulse, vector_addr/vector_level valid
//   vector_addr   delivered vector byte, held until next delivery
//   vector_level  mask level the CPU loads on entry (3 for NMI)
//   spurious      one-cycle pulse, maskable request vanished during ack
//   busy          sequencer is in any state other than IDLE

module irq_dispatch #(
  parameter int         ACK_CYCLES   = 2,
  parameter int         GUARD_CYCLES = 1,
  parameter logic [7:0] NMI_VECTOR   = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cpu_irq,
  input  logic       nmi,
  input  logic [7:0] irq_vector,
  input  logic [1:0] cpu_imask,
  input  logic       cpu_boundary,
  input  logic       cpu_irq_take,
  output logic       cpu_irq_req,
  output logic       irq_iack,
  output logic       vector_valid,
  output logic [7:0] vector_addr,
  output logic [1:0] vector_level,
  output logic       spurious,
  output logic       busy
);

  // The counter is shared by the acknowledge and the guard phases.
  localparam int MAX_CYCLES = (ACK_CYCLES > GUARD_CYCLES) ? ACK_CYCLES : GUARD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] ACK_LOAD   = CNT_W'(ACK_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    VEC,
    GUARD
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             src_nmi, src_nmi_n;
  logic [1:0]       lvl, lvl_n;

  logic             nmi_q;
  logic             nmi_pend;
  logic             take_nmi;

  logic             cand_valid;
  logic             cand_nmi;
  logic [1:0]       cand_level;
  logic [1:0]       mask_level;

  logic             iack_n;
  logic             vv_n;
  logic             spur_n;
  logic [7:0]       addr_n;
  logic [1:0]       vlevel_n;

  // Candidate selection, re-evaluated every cycle. A pending NMI beats any
  // maskable request and ignores the mask. For maskable requests only the
  // highest set level matters: if it is masked, every lower one is as well.
  always_comb begin
    mask_level = 2'd0;
    if (cpu_irq[3])
      mask_level = 2'd3;
    else if (cpu_irq[2])
      mask_level = 2'd2;
    else if (cpu_irq[1])
      mask_level = 2'd1;

    cand_valid = 1'b0;
    cand_nmi   = 1'b0;
    cand_level = 2'd0;
    if (nmi_pend) begin
      cand_valid = 1'b1;
      cand_nmi   = 1'b1;
      cand_level = 2'd3;
    end else if ((mask_level != 2'd0) && (mask_level > cpu_imask)) begin
      cand_valid = 1'b1;
      cand_level = mask_level;
    end
  end

  // NMI edge detector. nmi_q resets high so an NMI line already high when
  // reset is released does not count as an edge. The edge can arrive in any
  // state. Only taking the NMI clears the pending flag. A second edge while
  // the flag is pending merges into it.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (nmi && !nmi_q)
        nmi_pend <= 1'b1;
      else if (take_nmi)
        nmi_pend <= 1'b0;
    end
  end

  // Next-state logic. Every output is registered, so the values computed
  // here are the ones visible in the cycle after the transition.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    src_nmi_n = src_nmi;
    lvl_n     = lvl;
    take_nmi  = 1'b0;
    spur_n    = 1'b0;
    addr_n    = vector_addr;
    vlevel_n  = vector_level;

    case (state)
      IDLE: begin
        if (cand_valid)
          state_n = REQ;
      end

      // A withdrawn request wins over a take in the same cycle, so the
      // sequencer never latches a source that no longer exists.
      REQ: begin
        if (!cand_valid) begin
          state_n = IDLE;
        end else if (cpu_irq_take && cpu_boundary) begin
          src_nmi_n = cand_nmi;
          lvl_n     = cand_level;
          take_nmi  = cand_nmi;
          cnt_n     = ACK_LOAD;
          state_n   = ACK;
        end
      end

      // A count of one marks the last acknowledge cycle. In that cycle the
      // controller's vector byte is still valid, and the request line is
      // checked again to detect a spurious interrupt.
      ACK: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt <= CNT_ONE) begin
          if (src_nmi) begin
            addr_n   = NMI_VECTOR;
            vlevel_n = lvl;
            state_n  = VEC;
          end else if (cpu_irq[lvl]) begin
            addr_n   = irq_vector;
            vlevel_n = lvl;
            state_n  = VEC;
          end else begin
            spur_n  = 1'b1;
            cnt_n   = GUARD_LOAD;
            state_n = GUARD;
          end
        end
      end

      VEC: begin
        cnt_n   = GUARD_LOAD;
        state_n = GUARD;
      end

      GUARD: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt <= CNT_ONE)
          state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    iack_n = (state_n == ACK) && !src_nmi_n;
    vv_n   = (state_n == VEC);
  end

  // State and datapath registers. The output registers are decoded from
  // the next state, so the output timing matches the state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      src_nmi      <= 1'b0;
      lvl          <= 2'd0;
      cpu_irq_req  <= 1'b0;
      irq_iack     <= 1'b0;
      vector_valid <= 1'b0;
      vector_addr  <= 8'h00;
      vector_level <= 2'd0;
      spurious     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      src_nmi      <= src_nmi_n;
      lvl          <= lvl_n;
      cpu_irq_req  <= (state_n == REQ);
      irq_iack     <= iack_n;
      vector_valid <= vv_n;
      vector_addr  <= addr_n;
      vector_level <= vlevel_n;
      spurious     <= spur_n;
      busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch
//
// Directed bench for irq_dispatch with default parameters (ACK_CYCLES=2,
// GUARD_CYCLES=1, NMI_VECTOR=8'h02). Each table record gives the inputs
// for one cycle and the outputs expected just after the following edge.
// Hand-written sequences cover NMI arriving during a maskable acknowledge
// and reset during an acknowledge.

module tb_irq_dispatch;

  logic       clk;
  logic       reset;
  logic [3:0] cpu_irq;
  logic       nmi;
  logic [7:0] irq_vector;
  logic [1:0] cpu_imask;
  logic       cpu_boundary;
  logic       cpu_irq_take;
  logic       cpu_irq_req;
  logic       irq_iack;
  logic       vector_valid;
  logic [7:0] vector_addr;
  logic [1:0] vector_level;
  logic       spurious;
  logic       busy;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       rst;
    logic [3:0] irq;
    logic       nmi;
    logic [7:0] vec;
    logic [1:0] imask;
    logic       bnd;
    logic       take;
    logic       req;
    logic       iack;
    logic       vv;
    logic [7:0] addr;
    logic [1:0] lvl;
    logic       spur;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  irq_dispatch dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_irq      (cpu_irq),
    .nmi          (nmi),
    .irq_vector   (irq_vector),
    .cpu_imask    (cpu_imask),
    .cpu_boundary (cpu_boundary),
    .cpu_irq_take (cpu_irq_take),
    .cpu_irq_req  (cpu_irq_req),
    .irq_iack     (irq_iack),
    .vector_valid (vector_valid),
    .vector_addr  (vector_addr),
    .vector_level (vector_level),
    .spurious     (spurious),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic [3:0] irq, input logic nmi_i,
    input logic [7:0] vec, input logic [1:0] imask, input logic bnd,
    input logic take, input logic req, input logic iack, input logic vv,
    input logic [7:0] addr, input logic [1:0] lvl, input logic spur,
    input logic bsy);
    vec_t v;
    v.rst = rst;  v.irq = irq;   v.nmi = nmi_i; v.vec = vec;
    v.imask = imask; v.bnd = bnd; v.take = take;
    v.req = req;  v.iack = iack; v.vv = vv;     v.addr = addr;
    v.lvl = lvl;  v.spur = spur; v.busy = bsy;
    return v;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the record's inputs for one cycle, then move past the edge.
  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    cpu_irq      = v.irq;
    nmi          = v.nmi;
    irq_vector   = v.vec;
    cpu_imask    = v.imask;
    cpu_boundary = v.bnd;
    cpu_irq_take = v.take;
    tick();
  endtask

  task automatic checkVal(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " req"},   {7'd0, cpu_irq_req},  {7'd0, v.req});
    checkVal({tag, " iack"},  {7'd0, irq_iack},     {7'd0, v.iack});
    checkVal({tag, " vv"},    {7'd0, vector_valid}, {7'd0, v.vv});
    checkVal({tag, " addr"},  vector_addr,          v.addr);
    checkVal({tag, " level"}, {6'd0, vector_level}, {6'd0, v.lvl});
    checkVal({tag, " spur"},  {7'd0, spurious},     {7'd0, v.spur});
    checkVal({tag, " busy"},  {7'd0, busy},         {7'd0, v.busy});
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  initial begin
    logic found;
    n_checks = 0;
    n_fail   = 0;

    reset = 1'b1; cpu_irq = 4'b0; nmi = 1'b0; irq_vector = 8'h00;
    cpu_imask = 2'd0; cpu_boundary = 1'b0; cpu_irq_take = 1'b0;

    //         rst irq     nmi vec    im bnd tk   req ik vv addr  lv sp bsy
    // Reset state
    tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0));
    // Maskable basic with boundary gating (take w/o boundary ignored)
    tbl.push_back(mk(0, 4'b0100, 0, 8'h1C, 0, 0, 0,  1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 8'h1C, 0, 1, 0,  1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 8'h1C, 0, 0, 1,  1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 8'h1C, 0, 1, 1,  0, 1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 8'h1C, 0, 0, 0,  0, 1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 8'h1C, 0, 0, 0,  0, 0, 1, 8'h1C, 2, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h1C, 2, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h1C, 2, 0, 0));
    // Masking: level 1 blocked by mask 1, level 3 accepted
    tbl.push_back(mk(0, 4'b0010, 0, 8'h00, 1, 0, 0,  0, 0, 0, 8'h1C, 2, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 8'h00, 1, 0, 0,  0, 0, 0, 8'h1C, 2, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 8'h33, 1, 0, 0,  1, 0, 0, 8'h1C, 2, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 8'h33, 1, 1, 1,  0, 1, 0, 8'h1C, 2, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 8'h33, 1, 0, 0,  0, 1, 0, 8'h1C, 2, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 8'h33, 1, 0, 0,  0, 0, 1, 8'h33, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 0, 0,  0, 0, 0, 8'h33, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 0, 0,  0, 0, 0, 8'h33, 3, 0, 0));
    // NMI priority over fully masked level 3; no iack for NMI
    tbl.push_back(mk(0, 4'b1000, 1, 8'h55, 3, 0, 0,  0, 0, 0, 8'h33, 3, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 1, 8'h55, 3, 0, 0,  1, 0, 0, 8'h33, 3, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 1, 8'h55, 3, 1, 1,  0, 0, 0, 8'h33, 3, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 1, 8'h55, 3, 0, 0,  0, 0, 0, 8'h33, 3, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 1, 8'h55, 3, 0, 0,  0, 0, 1, 8'h02, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h02, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h02, 3, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h02, 3, 0, 0));
    // Withdraw in REQ
    tbl.push_back(mk(0, 4'b0100, 0, 8'h1C, 0, 0, 0,  1, 0, 0, 8'h02, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h1C, 0, 0, 0,  0, 0, 0, 8'h02, 3, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h02, 3, 0, 0));
    // Spurious: request cleared during ACK
    tbl.push_back(mk(0, 4'b0010, 0, 8'h44, 0, 0, 0,  1, 0, 0, 8'h02, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 8'h44, 0, 1, 1,  0, 1, 0, 8'h02, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h44, 0, 0, 0,  0, 1, 0, 8'h02, 3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h44, 0, 0, 0,  0, 0, 0, 8'h02, 3, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 0, 0, 0,  0, 0, 0, 8'h02, 3, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      runVec($sformatf("v%0d", i), tbl[i]);

    // NMI edge during a maskable ACK: maskable vector first, then NMI.
    runVec("nA req",   mk(0, 4'b0100, 0, 8'h1C, 0, 0, 0, 1, 0, 0, 8'h02, 3, 0, 1));
    runVec("nA take",  mk(0, 4'b0100, 0, 8'h1C, 0, 1, 1, 0, 1, 0, 8'h02, 3, 0, 1));
    runVec("nA edge",  mk(0, 4'b0100, 1, 8'h1C, 0, 0, 0, 0, 1, 0, 8'h02, 3, 0, 1));
    runVec("nA vec",   mk(0, 4'b0100, 1, 8'h1C, 0, 0, 0, 0, 0, 1, 8'h1C, 2, 0, 1));
    runVec("nA guard", mk(0, 4'b0000, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h1C, 2, 0, 1));
    runVec("nA idle",  mk(0, 4'b0000, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h1C, 2, 0, 0));
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (cpu_irq_req) found = 1'b1;
    end
    checkVal("nA nmi req timeout", {7'd0, found}, 8'd1);
    runVec("nA ntake", mk(0, 4'b0000, 1, 8'h99, 0, 1, 1, 0, 0, 0, 8'h1C, 2, 0, 1));
    cpu_boundary = 1'b0;
    cpu_irq_take = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (irq_iack) checkVal("nA nmi iack", {7'd0, irq_iack}, 8'd0);
      if (vector_valid) found = 1'b1;
    end
    checkVal("nA nmi vv timeout", {7'd0, found}, 8'd1);
    checkVal("nA nmi addr", vector_addr, 8'h02);
    checkVal("nA nmi level", {6'd0, vector_level}, 8'd3);
    tick();
    tick();
    checkVal("nA done busy", {7'd0, busy}, 8'd0);

    // Reset during ACK, with NMI held high across reset release.
    runVec("rB req",   mk(0, 4'b1000, 1, 8'h77, 0, 0, 0, 1, 0, 0, 8'h02, 3, 0, 1));
    runVec("rB take",  mk(0, 4'b1000, 1, 8'h77, 0, 1, 1, 0, 1, 0, 8'h02, 3, 0, 1));
    runVec("rB reset", mk(1, 4'b1000, 1, 8'h77, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    runVec("rB rel0",  mk(0, 4'b0000, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    runVec("rB rel1",  mk(0, 4'b0000, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    runVec("rB rel2",  mk(0, 4'b0000, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    runVec("rB low",   mk(0, 4'b0000, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    runVec("rB edge",  mk(0, 4'b0000, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    runVec("rB nreq",  mk(0, 4'b0000, 1, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
